// File: rtl/maze_blast.sv
// maze_blast: bomb blast engine that floods T_FLAME along four arms of a 25x17 tile maze RAM
// Ports: clk/reset (sync, active-high); active = video owns RAM read port;
//   req_valid/req_ready/req_x/req_y/req_range = blast request handshake;
//   ram_raddr/ram_rdata = 1-cycle latency read port, ram_waddr/ram_wdata/ram_we = write port;
//   done = one-cycle completion pulse.
// Option: define MAZE_BLAST_SCORE_EN to add bricks_cnt, a saturating count of destroyed bricks.
module maze_blast #(
  parameter int          RANGE_W = 3,
  parameter logic [3:0]  T_HARD  = 4'h1,
  parameter logic [3:0]  T_SOFT  = 4'h2,
  parameter logic [3:0]  T_FLAME = 4'h3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_x,
  input  logic [4:0]         req_y,
  input  logic [RANGE_W-1:0] req_range,
  output logic [9:0]         ram_raddr,
  input  logic [3:0]         ram_rdata,
  output logic [9:0]         ram_waddr,
  output logic [3:0]         ram_wdata,
  output logic               ram_we,
`ifdef MAZE_BLAST_SCORE_EN
  output logic [7:0]         bricks_cnt,
`endif
  output logic               done
);
  typedef enum logic [2:0] {S_IDLE, S_CENTER, S_ARM, S_READ, S_EVAL, S_DONE} state_t;
  localparam logic [RANGE_W:0] K1 = (RANGE_W+1)'(1);
  state_t             r_state, w_nx, w_end_nx;
  logic [4:0]         r_x, r_y;
  logic [RANGE_W-1:0] r_rng;
  logic [RANGE_W:0]   r_k, w_k1;
  logic [1:0]         r_dir;
  logic               r_rd_ok, r_hold, r_done;
  logic [3:0]         r_tile, w_code;
  logic [15:0]        w_cx, w_cy, w_nx_x, w_nx_y;
  logic               w_cur_ok, w_nxt_ok, w_hard, w_soft, w_end, w_step, w_we;
  // Coordinates are widened so that stepping below 0 wraps to a huge value and fails the bounds test.
  function automatic logic [15:0] f_step(input logic [4:0] c, input logic plus, input logic minus,
                                         input logic [RANGE_W:0] k);
    return plus ? 16'(c) + 16'(k) : minus ? 16'(c) - 16'(k) : 16'(c);
  endfunction
  assign w_k1     = r_k + K1;
  assign w_cx     = f_step(r_x, r_dir == 2'd0, r_dir == 2'd1, r_k);
  assign w_cy     = f_step(r_y, r_dir == 2'd2, r_dir == 2'd3, r_k);
  assign w_nx_x   = f_step(r_x, r_dir == 2'd0, r_dir == 2'd1, w_k1);
  assign w_nx_y   = f_step(r_y, r_dir == 2'd2, r_dir == 2'd3, w_k1);
  assign w_cur_ok = (w_cx <= 16'd24) && (w_cy <= 16'd16) && (r_k <= {1'b0, r_rng});
  assign w_nxt_ok = (w_nx_x <= 16'd24) && (w_nx_y <= 16'd16) && (w_k1 <= {1'b0, r_rng});
  // Read data is only valid in the first EVAL cycle; a stalled EVAL reuses the captured tile.
  assign w_code   = r_hold ? r_tile : ram_rdata;
  assign w_hard   = w_code == T_HARD;
  assign w_soft   = w_code == T_SOFT;
  assign w_end_nx = (r_dir == 2'd3) ? S_DONE : S_ARM;
  assign w_end    = (r_state == S_ARM && !w_cur_ok) ||
                    (r_state == S_EVAL && r_rd_ok && (w_hard || (!active && (w_soft || !w_nxt_ok))));
  assign w_step   = r_state == S_EVAL && r_rd_ok && !w_hard && !w_soft && !active && w_nxt_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_rng   <= '0;
      r_k     <= K1;
      r_dir   <= 2'd0;
      r_rd_ok <= 1'b0;
      r_hold  <= 1'b0;
      r_tile  <= 4'h0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nx;
      r_done  <= r_state == S_DONE;
      r_hold  <= r_state == S_EVAL && w_nx == S_EVAL;
      r_tile  <= w_code;
      if (r_state == S_READ) r_rd_ok <= !active;
      if (req_valid && req_ready) begin
        r_x   <= req_x;
        r_y   <= req_y;
        r_rng <= req_range;
        r_k   <= K1;
        r_dir <= 2'd0;
      end else if (w_end) begin
        r_k   <= K1;
        r_dir <= r_dir + 2'd1;
      end else if (w_step) r_k <= w_k1;
    end
  end
  always_comb begin
    w_nx = S_IDLE;
    case (r_state)
      S_IDLE:   w_nx = req_valid ? S_CENTER : S_IDLE;
      S_CENTER: w_nx = active ? S_CENTER : S_ARM;
      S_ARM:    w_nx = w_cur_ok ? S_READ : w_end_nx;
      S_READ:   w_nx = active ? S_READ : S_EVAL;
      S_EVAL:   w_nx = !r_rd_ok ? S_READ : w_hard ? w_end_nx : active ? S_EVAL : w_step ? S_READ : w_end_nx;
      default:  w_nx = S_IDLE;
    endcase
  end
  always_comb begin
    w_we      = !active && (r_state == S_CENTER || (r_state == S_EVAL && r_rd_ok && !w_hard));
    req_ready = r_state == S_IDLE;
    ram_we    = w_we;
    ram_waddr = !w_we ? 10'd0 : (r_state == S_CENTER) ? {r_y, r_x} : {w_cy[4:0], w_cx[4:0]};
    ram_wdata = w_we ? T_FLAME : 4'h0;
    ram_raddr = (r_state == S_READ) ? {w_cy[4:0], w_cx[4:0]} : 10'd0;
    done      = r_done;
  end
`ifdef MAZE_BLAST_SCORE_EN
  logic [7:0] r_bricks;
  always_ff @(posedge clk) begin
    if (reset) r_bricks <= 8'd0;
    else if (r_state == S_EVAL && w_we && w_soft && r_bricks != 8'hFF) r_bricks <= r_bricks + 8'd1;
  end
  assign bricks_cnt = r_bricks;
`endif
endmodule

// File: tb/tb_maze_blast.sv
// tb_maze_blast: directed self-checking bench for maze_blast with a behavioural maze RAM
module tb_maze_blast;
  logic       clk = 1'b0, reset = 1'b1, active = 1'b0, req_valid = 1'b0;
  logic       req_ready, ram_we, done;
  logic [4:0] req_x = '0, req_y = '0;
  logic [2:0] req_range = '0;
  logic [9:0] ram_raddr, ram_waddr;
  logic [3:0] ram_rdata = 4'h0, ram_wdata;
`ifdef MAZE_BLAST_SCORE_EN
  logic [7:0] bricks_cnt;
`endif
  logic [3:0] mem [1024];
  logic [3:0] ref_mem [1024];
  logic [9:0] wq_a [$];
  int         wq_t [$];
  int         cyc = 0, t_acc = 0, t_done = 0, n_acc = 0, n_done = 0, n_bad = 0;
  int         n_cmp = 0, n_err = 0;

  maze_blast dut (
    .clk(clk), .reset(reset), .active(active), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_range(req_range), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
`ifdef MAZE_BLAST_SCORE_EN
    .bricks_cnt(bricks_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // While video owns the port the RAM returns a wall code, so any use of stale data is visible.
  always @(posedge clk) begin
    ram_rdata <= active ? 4'h1 : mem[ram_raddr];
    if (ram_we) mem[ram_waddr] = ram_wdata;
  end
  always @(negedge clk) begin
    if (ram_we) begin
      wq_a.push_back(ram_waddr);
      wq_t.push_back(cyc);
      if (active) n_bad++;
    end
    if (ram_raddr != 10'd0 && (ram_raddr[4:0] > 5'd24 || ram_raddr[9:5] > 5'd16)) n_bad++;
    if (req_valid && req_ready && !reset) begin t_acc = cyc; n_acc++; end
    if (done) begin t_done = cyc; n_done++; end
  end

  function automatic logic [9:0] ta(input int x, input int y);
    return 10'(y * 32 + x);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    wq_a.delete();
    wq_t.delete();
  endtask

  task automatic blast_start(input int x, input int y, input int r);
    @(posedge clk); #1;
    req_x = 5'(x); req_y = 5'(y); req_range = 3'(r); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n0 = n_done;
    for (int i = 0; i < 400 && n_done == n0; i++) @(posedge clk);
    #1;
    n_cmp++;
    if (n_done == n0) begin n_err++; $display("FAIL %s_timeout: done count %0d, required %0d", nm, n_done, n0 + 1); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, done, ram_we} !== 3'b100) begin n_err++; $display("FAIL reset_ctl: {ready,done,we}=%b required 100", {req_ready, done, ram_we}); end
    n_cmp++;
    if ({ram_raddr, ram_waddr, ram_wdata} !== 24'd0) begin n_err++; $display("FAIL reset_bus: raddr=%0d waddr=%0d wdata=%0d required 0", ram_raddr, ram_waddr, ram_wdata); end
`ifdef MAZE_BLAST_SCORE_EN
    n_cmp++;
    if (bricks_cnt !== 8'd0) begin n_err++; $display("FAIL reset_bricks: got %0d required 0", bricks_cnt); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_open();
    logic [9:0] ea [5];
    int         et [5];
    ea = '{ta(5,5), ta(6,5), ta(4,5), ta(5,6), ta(5,4)};
    et = '{1, 4, 7, 10, 13};
    clear_mem();
    blast_start(5, 5, 1);
    wait_done("open");
    n_cmp++;
    if (wq_a.size() != 5) begin n_err++; $display("FAIL open_nwrites: got %0d required 5", wq_a.size()); end
    for (int i = 0; i < 5 && i < wq_a.size(); i++) begin
      n_cmp++;
      if (wq_a[i] !== ea[i] || wq_t[i] - t_acc != et[i]) begin
        n_err++;
        $display("FAIL open_write%0d: addr %0d at T+%0d, required addr %0d at T+%0d", i, wq_a[i], wq_t[i] - t_acc, ea[i], et[i]);
      end
    end
    n_cmp++;
    if (t_done - t_acc != 15) begin n_err++; $display("FAIL open_done_time: T+%0d required T+15", t_done - t_acc); end
    n_cmp++;
    if (mem[ta(6,5)] !== 4'h3) begin n_err++; $display("FAIL open_flame: tile %0h required 3", mem[ta(6,5)]); end
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
  endtask

  task automatic test_range0();
    clear_mem();
    blast_start(10, 10, 0);
    wait_done("range0");
    n_cmp++;
    if (wq_a.size() != 1 || wq_a[0] !== ta(10,10)) begin n_err++; $display("FAIL range0_writes: count %0d first %0d, required 1 at %0d", wq_a.size(), wq_a.size() ? wq_a[0] : 10'd0, ta(10,10)); end
    n_cmp++;
    if (t_done - t_acc != 7) begin n_err++; $display("FAIL range0_done_time: T+%0d required T+7", t_done - t_acc); end
  endtask

  task automatic test_hard();
    clear_mem();
    mem[ta(7,5)] = 4'h1;
    blast_start(5, 5, 3);
    wait_done("hard");
    n_cmp++;
    if ({mem[ta(6,5)], mem[ta(7,5)], mem[ta(8,5)]} !== 12'h310) begin n_err++; $display("FAIL hard_arm: tiles 6,7,8 = %h required 310", {mem[ta(6,5)], mem[ta(7,5)], mem[ta(8,5)]}); end
    n_cmp++;
    if ({mem[ta(2,5)], mem[ta(1,5)]} !== 8'h30) begin n_err++; $display("FAIL hard_range_edge: tiles 2,1 = %h required 30", {mem[ta(2,5)], mem[ta(1,5)]}); end
  endtask

  task automatic test_soft();
`ifdef MAZE_BLAST_SCORE_EN
    logic [7:0] b0 = bricks_cnt;
`endif
    clear_mem();
    mem[ta(6,5)] = 4'h2;
    blast_start(5, 5, 3);
    wait_done("soft");
    n_cmp++;
    if ({mem[ta(6,5)], mem[ta(7,5)]} !== 8'h30) begin n_err++; $display("FAIL soft_arm: tiles 6,7 = %h required 30", {mem[ta(6,5)], mem[ta(7,5)]}); end
`ifdef MAZE_BLAST_SCORE_EN
    n_cmp++;
    if (bricks_cnt !== b0 + 8'd1) begin n_err++; $display("FAIL soft_bricks: got %0d required %0d", bricks_cnt, b0 + 8'd1); end
`endif
  endtask

  task automatic test_corner();
    logic [9:0] ea [5];
    logic [9:0] eb [5];
    ea = '{ta(0,0), ta(1,0), ta(2,0), ta(0,1), ta(0,2)};
    eb = '{ta(24,16), ta(23,16), ta(22,16), ta(24,15), ta(24,14)};
    clear_mem();
    blast_start(0, 0, 2);
    wait_done("corner_lo");
    n_cmp++;
    if (wq_a.size() != 5) begin n_err++; $display("FAIL corner_lo_nwrites: got %0d required 5", wq_a.size()); end
    for (int i = 0; i < 5 && i < wq_a.size(); i++) begin
      n_cmp++;
      if (wq_a[i] !== ea[i]) begin n_err++; $display("FAIL corner_lo_write%0d: addr %0d required %0d", i, wq_a[i], ea[i]); end
    end
    n_cmp++;
    if (t_done - t_acc != 15) begin n_err++; $display("FAIL corner_lo_done_time: T+%0d required T+15", t_done - t_acc); end
    clear_mem();
    blast_start(24, 16, 2);
    wait_done("corner_hi");
    n_cmp++;
    if (wq_a.size() != 5) begin n_err++; $display("FAIL corner_hi_nwrites: got %0d required 5", wq_a.size()); end
    for (int i = 0; i < 5 && i < wq_a.size(); i++) begin
      n_cmp++;
      if (wq_a[i] !== eb[i]) begin n_err++; $display("FAIL corner_hi_write%0d: addr %0d required %0d", i, wq_a[i], eb[i]); end
    end
  endtask

  task automatic test_active(input int start, input int len, input int done_off, input string nm);
    int diffs = 0;
    clear_mem();
    blast_start(5, 5, 1);
    repeat (start) @(posedge clk);
    #1 active = 1'b1;
    repeat (len) @(posedge clk);
    #1 active = 1'b0;
    wait_done(nm);
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0 || wq_a.size() != 5) begin n_err++; $display("FAIL %s_image: %0d tiles differ, %0d writes, required 0 and 5", nm, diffs, wq_a.size()); end
    n_cmp++;
    if (t_done - t_acc != done_off) begin n_err++; $display("FAIL %s_done_time: T+%0d required T+%0d", nm, t_done - t_acc, done_off); end
  endtask

  task automatic test_reset_mid();
    int n0;
    clear_mem();
    n0 = n_done;
    blast_start(5, 5, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({ram_we, req_ready} !== 2'b01) begin n_err++; $display("FAIL reset_mid_ctl: {we,ready}=%b required 01", {ram_we, req_ready}); end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    n_cmp++;
    if (n_done != n0 || wq_a.size() != 1) begin n_err++; $display("FAIL reset_mid_abort: %0d done pulses, %0d writes, required 0 and 1", n_done - n0, wq_a.size()); end
  endtask

  task automatic test_ignore();
    int a0;
    clear_mem();
    a0 = n_acc;
    blast_start(10, 10, 2);
    req_x = 5'd3; req_y = 5'd3; req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    wait_done("ignore");
    repeat (5) @(posedge clk);
    n_cmp++;
    if (n_acc != a0 + 1 || mem[ta(3,3)] !== 4'h0) begin n_err++; $display("FAIL ignore_busy: %0d accepts, tile(3,3)=%0h, required 1 and 0", n_acc - a0, mem[ta(3,3)]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    test_reset();
    test_open();
    test_range0();
    test_hard();
    test_soft();
    test_corner();
    test_active(2, 4, 19, "active_read");
    test_active(3, 2, 17, "active_eval");
    test_reset_mid();
    test_ignore();
    n_cmp++;
    if (n_bad != 0) begin n_err++; $display("FAIL ram_rules: %0d writes under active or out-of-maze reads, required 0", n_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
